// File: rtl/map_sel_driver_pkg.sv
// Shared definitions for the two-map display selector.
// Holds the selector FSM state encoding, the default map width and the
// default map patterns (also used by the downstream mux bench).
package map_sel_driver_pkg;

    localparam int MAP_W = 7;

    localparam logic [MAP_W-1:0] MAP0_INIT = 7'b1000001;
    localparam logic [MAP_W-1:0] MAP1_INIT = 7'b1100011;

    typedef enum logic {
        ST_IDLE_MAN = 1'b0,
        ST_AUTO     = 1'b1
    } state_t;

endpackage

// File: rtl/map_sel_driver_btn_sync_edge.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector. Produces a one-cycle press pulse per rising edge of btn.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   btn     - raw asynchronous button, active-high
//   press   - one-cycle pulse, high in the cycle the synchronized level rises
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

endmodule

// File: rtl/map_sel_driver.sv
// Source side of the two-map display selector. Holds the two map
// registers and drives them plus the select line into the 2:1 map mux.
// Select toggles on a button press (manual) or every PERIOD cycles (auto).
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   wr_en/addr/data  - single-cycle map write
//   mode             - 0 manual, 1 auto
//   btn              - raw toggle button
//   mapa0, mapa1     - registered maps to the mux
//   sel              - mux select (0 selects mapa0)
//   toggled          - one-cycle pulse in the cycle sel changes
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_IDLE_MAN | manual: press toggles sel, counter held at 0
// ST_AUTO     | auto: counter runs, sel toggles at PERIOD-1 wrap
module map_sel_driver #(
    parameter int                MAP_W     = map_sel_driver_pkg::MAP_W,
    parameter int                PERIOD    = 50,
    parameter int                CNT_W     = 16,
    parameter logic [MAP_W-1:0]  MAP0_INIT = map_sel_driver_pkg::MAP0_INIT,
    parameter logic [MAP_W-1:0]  MAP1_INIT = map_sel_driver_pkg::MAP1_INIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             wr_addr,
    input  logic [MAP_W-1:0] wr_data,
    input  logic             mode,
    input  logic             btn,
    output logic [MAP_W-1:0] mapa0,
    output logic [MAP_W-1:0] mapa1,
    output logic             sel,
    output logic             toggled
);

    import map_sel_driver_pkg::*;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(PERIOD - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sel_nxt;
    logic             tog_nxt;
    logic             press;

    btn_sync_edge u_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .press   (press)
    );

    // Map writes are independent of the select logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mapa0 <= MAP0_INIT;
            mapa1 <= MAP1_INIT;
        end else if (wr_en) begin
            if (wr_addr) mapa1 <= wr_data;
            else         mapa0 <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE_MAN;
            cnt     <= '0;
            sel     <= 1'b0;
            toggled <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel     <= sel_nxt;
            toggled <= tog_nxt;
        end
    end

    // A mode change wins over press / terminal count in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        tog_nxt   = 1'b0;
        case (state)
            ST_IDLE_MAN: begin
                cnt_nxt = '0;
                if (mode) begin
                    state_nxt = ST_AUTO;
                end else if (press) begin
                    sel_nxt = ~sel;
                    tog_nxt = 1'b1;
                end
            end
            ST_AUTO: begin
                if (!mode) begin
                    state_nxt = ST_IDLE_MAN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_TC) begin
                    cnt_nxt = '0;
                    sel_nxt = ~sel;
                    tog_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE_MAN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
